// File: rtl/ad_ip_jesd204_tpl_adc_pnmon.sv
// PN9/PN23 pattern monitor for one converter channel: self-seeds from incoming
// data while out of sync, free-runs once locked, and reports mismatches.
module ad_ip_jesd204_tpl_adc_pnmon #(
    parameter int DATA_PATH_WIDTH = 2,
    parameter int OOS_THRESHOLD   = 16
) (
    input  logic                          link_clk,
    input  logic                          link_resetn,
    input  logic                          valid,
    input  logic [DATA_PATH_WIDTH*16-1:0] data,
    input  logic [3:0]                    pn_seq_sel,
    output logic                          pn_err,
    output logic                          pn_oos
);

    localparam int unsigned DW = DATA_PATH_WIDTH * 16;
    localparam int unsigned CW = $clog2(OOS_THRESHOLD + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OOS_THRESHOLD - 1);

    typedef enum logic {
        ST_OOS,
        ST_SYNC
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] seed, seed_nxt;
    logic [DW-1:0] data_q, expected;
    logic          valid_q;
    logic [3:0]    sel_q;
    logic          err_q, err_nxt;
    logic          match, sel_chg, sel_rsvd;

    // Stream position j lives at bit 16*(j/16)+15-(j%16), which equals j^15.
    function automatic logic [DW-1:0] pn_advance(input logic [DW-1:0] r, input logic long_seq);
        logic [DW+22:0] s;
        logic [DW-1:0]  e;
        s = '0;
        e = '0;
        if (long_seq) begin
            for (int unsigned i = 0; i < 23; i++) s[i] = r[(DW - 23 + i) ^ 15];
            for (int unsigned n = 23; n < DW + 23; n++) s[n] = s[n-23] ^ s[n-18];
            for (int unsigned j = 0; j < DW; j++) e[j ^ 15] = s[23 + j];
        end else begin
            for (int unsigned i = 0; i < 9; i++) s[i] = r[(DW - 9 + i) ^ 15];
            for (int unsigned n = 9; n < DW + 9; n++) s[n] = s[n-9] ^ s[n-5];
            for (int unsigned j = 0; j < DW; j++) e[j ^ 15] = s[9 + j];
        end
        return e;
    endfunction

    assign sel_chg  = (pn_seq_sel != sel_q);
    assign sel_rsvd = |sel_q[3:1];
    assign expected = pn_advance(seed, sel_q[0]);
    assign match    = (data_q == expected) && (|data_q);

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            data_q  <= data;
            valid_q <= valid;
            sel_q   <= pn_seq_sel;
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            state <= ST_OOS;
            cnt   <= '0;
            seed  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            seed  <= seed_nxt;
            err_q <= err_nxt;
        end
    end

    // Lock decision is taken in the compare stage so the seed of the next word
    // already sees the updated state; the outputs are one register further out.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        seed_nxt  = seed;
        err_nxt   = 1'b0;
        if (sel_chg || sel_rsvd) begin
            state_nxt = ST_OOS;
            cnt_nxt   = '0;
            seed_nxt  = '0;
        end else if (valid_q) begin
            seed_nxt = (state == ST_OOS) ? data_q : expected;
            case (state)
                ST_OOS: begin
                    if (!match) begin
                        cnt_nxt = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_SYNC;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_SYNC: begin
                    err_nxt = !match;
                    if (match) begin
                        cnt_nxt = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_OOS;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: state_nxt = ST_OOS;
            endcase
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            pn_oos <= 1'b1;
            pn_err <= 1'b0;
        end else if (sel_chg) begin
            pn_oos <= 1'b1;
            pn_err <= 1'b0;
        end else begin
            pn_oos <= (state == ST_OOS);
            pn_err <= err_q;
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pnmon.sv
// Directed bench for the PN monitor: a word-level reference model predicts
// pn_oos/pn_err every cycle, with literal checks on lock/loss timing.
module tb_ad_ip_jesd204_tpl_adc_pnmon;

    localparam int W   = 32;
    localparam int THR = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [W-1:0] data;
    logic [3:0]   sel;
    logic         pn_err;
    logic         pn_oos;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;

    ad_ip_jesd204_tpl_adc_pnmon #(
        .DATA_PATH_WIDTH(2),
        .OOS_THRESHOLD(THR)
    ) dut (
        .link_clk(clk),
        .link_resetn(rst_n),
        .valid(valid),
        .data(data),
        .pn_seq_sel(sel),
        .pn_err(pn_err),
        .pn_oos(pn_oos)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected next word: unpack stream bits (sample 0 first, MSB first),
    // extend with the recurrence, repack.
    function automatic logic [W-1:0] model_pn(input logic [W-1:0] r, input bit long_seq);
        bit q[$];
        int len, tap;
        logic [W-1:0] res;
        len = long_seq ? 23 : 9;
        tap = long_seq ? 18 : 5;
        for (int j = W - len; j < W; j++) q.push_back(r[16 * (j / 16) + 15 - (j % 16)]);
        for (int j = 0; j < W; j++) q.push_back(q[q.size() - len] ^ q[q.size() - tap]);
        res = '0;
        for (int j = 0; j < W; j++) res[16 * (j / 16) + 15 - (j % 16)] = q[len + j];
        return res;
    endfunction

    // Word-level reference state plus a two-deep output delay line.
    int          m_cnt;
    bit          m_sync;
    logic [W-1:0] m_r;
    logic [3:0]  m_sel;
    bit          p0_err, p0_oos, p1_err, p1_oos;
    bit          exp_err, exp_oos;

    task automatic model_reset();
        m_cnt = 0; m_sync = 0; m_r = '0; m_sel = '0;
        p0_err = 0; p0_oos = 1; p1_err = 0; p1_oos = 1;
        exp_err = 0; exp_oos = 1;
    endtask

    task automatic model_step();
        bit r_err, hit;
        logic [W-1:0] e;
        exp_err = p1_err; exp_oos = p1_oos;
        p1_err = p0_err;  p1_oos = p0_oos;
        if (sel != m_sel) begin
            exp_err = 0; exp_oos = 1; p1_err = 0; p1_oos = 1;
            m_sync = 0; m_cnt = 0; m_r = '0;
        end
        m_sel = sel;
        r_err = 0;
        if (sel > 4'd1) begin
            m_sync = 0; m_cnt = 0; m_r = '0;
        end else if (valid) begin
            e   = model_pn(m_r, sel == 4'd1);
            hit = (data == e) && (data != '0);
            m_r = m_sync ? e : data;
            if (!m_sync) begin
                m_cnt = hit ? m_cnt + 1 : 0;
                if (m_cnt == THR) begin m_sync = 1; m_cnt = 0; end
            end else begin
                r_err = !hit;
                m_cnt = hit ? 0 : m_cnt + 1;
                if (m_cnt == THR) begin m_sync = 0; m_cnt = 0; end
            end
        end
        p0_err = r_err; p0_oos = !m_sync;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("oos", {31'b0, pn_oos}, {31'b0, exp_oos});
            check("err", {31'b0, pn_err}, {31'b0, exp_err});
            if (pn_err === 1'b1) err_seen++;
        end
    end

    task automatic cyc(input bit v, input logic [W-1:0] d);
        valid = v;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] w, w23;
    int e0;

    initial begin
        rst_n = 1'b0; sel = 4'd0; valid = 1'b0; data = '0;

        check("pin_pn9", model_pn(32'hFFFF_FFFF, 1'b0), 32'h2E64_07BE);
        check("pin_pn23", model_pn(32'hFFFF_FFFF, 1'b1), 32'h3E00_0000);

        repeat (6) cyc(1'($urandom_range(0, 1)), $urandom());
        check("rst_oos", {31'b0, pn_oos}, 32'd1);
        check("rst_err", {31'b0, pn_err}, 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, '0);
        check("post_rst_oos", {31'b0, pn_oos}, 32'd1);

        // Lock on PN9: word 0 seeds, words 1..16 match
        e0 = err_seen;
        w = 32'hFFFF_FFFF;
        cyc(1'b1, w);
        for (int k = 1; k <= 16; k++) begin w = model_pn(w, 1'b0); cyc(1'b1, w); end
        w = model_pn(w, 1'b0); cyc(1'b1, w);
        check("lock_t1", {31'b0, pn_oos}, 32'd1);
        w = model_pn(w, 1'b0); cyc(1'b1, w);
        check("lock_t2", {31'b0, pn_oos}, 32'd0);
        check("lock_err", err_seen - e0, 32'd0);

        // Single flipped bit while locked
        for (int k = 0; k < 3; k++) begin w = model_pn(w, 1'b0); cyc(1'b1, w); end
        e0 = err_seen;
        w = model_pn(w, 1'b0); cyc(1'b1, w ^ 32'h0000_0100);
        w = model_pn(w, 1'b0); cyc(1'b1, w);
        check("flip_t1", {31'b0, pn_err}, 32'd0);
        w = model_pn(w, 1'b0); cyc(1'b1, w);
        check("flip_t2", {31'b0, pn_err}, 32'd1);
        for (int k = 0; k < 3; k++) begin w = model_pn(w, 1'b0); cyc(1'b1, w); end
        check("flip_cnt", err_seen - e0, 32'd1);
        check("flip_oos", {31'b0, pn_oos}, 32'd0);

        // Loss of lock on 16 all-zero words
        e0 = err_seen;
        repeat (16) cyc(1'b1, '0);
        cyc(1'b0, '0);
        check("loss_t1", {31'b0, pn_oos}, 32'd0);
        cyc(1'b0, '0);
        check("loss_t2", {31'b0, pn_oos}, 32'd1);
        cyc(1'b0, '0);
        check("loss_cnt", err_seen - e0, 32'd16);

        // Relock PN9, then switch to PN23
        for (int k = 0; k < 17; k++) begin w = model_pn(w, 1'b0); cyc(1'b1, w); end
        repeat (3) cyc(1'b0, '0);
        check("relock9", {31'b0, pn_oos}, 32'd0);
        sel = 4'd1;
        cyc(1'b0, '0);
        check("selchg_oos", {31'b0, pn_oos}, 32'd1);
        repeat (2) cyc(1'b0, '0);
        w23 = 32'h1234_5678;
        cyc(1'b1, w23);
        for (int k = 1; k <= 16; k++) begin w23 = model_pn(w23, 1'b1); cyc(1'b1, w23); end
        cyc(1'b0, '0);
        check("lock23_t1", {31'b0, pn_oos}, 32'd1);
        cyc(1'b0, '0);
        check("lock23_t2", {31'b0, pn_oos}, 32'd0);

        // Back to PN9 with a gap after every valid word
        repeat (3) cyc(1'b0, '0);
        sel = 4'd0;
        repeat (3) cyc(1'b0, $urandom());
        for (int k = 0; k <= 16; k++) begin
            w = model_pn(w, 1'b0);
            cyc(1'b1, w);
            if (k < 16) cyc(1'b0, $urandom());
        end
        cyc(1'b0, $urandom());
        check("gap_t1", {31'b0, pn_oos}, 32'd1);
        cyc(1'b0, $urandom());
        check("gap_t2", {31'b0, pn_oos}, 32'd0);

        // Reserved code holds OOS regardless of data
        e0 = err_seen;
        sel = 4'd7;
        for (int k = 0; k < 40; k++) begin w = model_pn(w, 1'b0); cyc(1'b1, w); end
        check("rsvd_oos", {31'b0, pn_oos}, 32'd1);
        check("rsvd_err", err_seen - e0, 32'd0);

        // Relock, then assert reset mid-stream
        sel = 4'd0;
        repeat (3) cyc(1'b0, '0);
        for (int k = 0; k < 17; k++) begin w = model_pn(w, 1'b0); cyc(1'b1, w); end
        repeat (2) begin w = model_pn(w, 1'b0); cyc(1'b1, w); end
        check("pre_rst_oos", {31'b0, pn_oos}, 32'd0);
        e0 = err_seen;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_oos", {31'b0, pn_oos}, 32'd1);
        check("mid_rst_err", {31'b0, pn_err}, 32'd0);
        repeat (3) cyc(1'b1, $urandom());
        rst_n = 1'b1;
        w = model_pn(w, 1'b0); cyc(1'b1, w);
        check("rel_oos", {31'b0, pn_oos}, 32'd1);
        repeat (4) begin w = model_pn(w, 1'b0); cyc(1'b1, w); end
        check("rel_err", err_seen - e0, 32'd0);
        repeat (3) cyc(1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_pnmon.md
AD_IP_JESD204_TPL_ADC_PNMON -- requirements
Module: ad_ip_jesd204_tpl_adc_pnmon

Interface
REQ-001 SHALL have parameter DATA_PATH_WIDTH, default 2, meaning 16-bit samples per channel per cycle; legal range 2..8.
REQ-002 SHALL have parameter OOS_THRESHOLD, default 16, meaning consecutive matching words to lock and consecutive mismatching words to lose lock; legal range 2..255.
REQ-003 SHALL have port link_clk, input, 1 bit: the only clock; all state on its rising edge.
REQ-004 SHALL have port link_resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port valid, input, 1 bit: data word qualifier.
REQ-006 SHALL have port data, input, DATA_PATH_WIDTH*16 bits: raw converter samples; sample i at bits [16i+15:16i].
REQ-007 SHALL have port pn_seq_sel, input, 4 bits: sequence select from the regmap channel; 0 = PN9, 1 = PN23, others reserved.
REQ-008 SHALL have port pn_err, output, 1 bit: per-word mismatch pulse while locked.
REQ-009 SHALL have port pn_oos, output, 1 bit: out-of-sync status.

Function
REQ-010 SHALL define stream order as sample 0 first and MSB first within a sample.
REQ-011 SHALL use recurrence b[n]=b[n-9]^b[n-5] for PN9 and b[n]=b[n-23]^b[n-18] for PN23.
REQ-012 SHALL, per valid word D_k, compute expected word E_k by advancing the selected recurrence DATA_PATH_WIDTH*16 bits from seed register R, taking the last 9 or 23 stream bits of R as state.
REQ-013 SHALL set match_k = (D_k == E_k) and (D_k != 0); an all-zero word is never a match.
REQ-014 SHALL update R <= D_k when pn_oos = 1, and R <= E_k when pn_oos = 0 (self-seeding while unlocked, free-running while locked).
REQ-015 SHALL keep a counter cnt of ceil(log2(OOS_THRESHOLD+1)) bits.
REQ-016 SHALL, in state OOS: on match increment cnt; on reaching OOS_THRESHOLD, enter SYNC and clear cnt; on mismatch clear cnt.
REQ-017 SHALL, in state SYNC: on mismatch increment cnt; on reaching OOS_THRESHOLD, enter OOS and clear cnt; on match clear cnt.
REQ-018 SHALL drive pn_oos = 1 in OOS and 0 in SYNC, registered.
REQ-019 SHALL assert pn_err for exactly one cycle per valid word that mismatches while in SYNC, including the word that causes entry to OOS; pn_err is 0 in OOS.
REQ-020 SHALL use a fixed latency: input registered at edge t, compare registered at t+1, pn_err/pn_oos updated at t+2.
REQ-021 SHALL hold R, cnt and state unchanged and drive pn_err 0 for cycles with valid = 0.
REQ-022 SHALL register pn_seq_sel, and on any change force OOS, cnt = 0, R = 0 and pn_err = 0 in the following cycle.
REQ-023 SHALL hold OOS, cnt = 0 and pn_err = 0 for as long as pn_seq_sel is reserved.

Reset
REQ-024 SHALL asynchronously reset, while link_resetn = 0: R = 0, cnt = 0, all pipeline registers 0, state OOS, pn_oos = 1, pn_err = 0.
REQ-025 SHALL leave the state machine in OOS on the first rising edge after release, requiring relock through REQ-016.
REQ-026 SHALL return to OOS on reset asserted mid-stream, with no pn_err pulse generated.

Verification
REQ-027 SHALL cover reset: link_resetn = 0 with random data -> pn_oos = 1 and pn_err = 0 throughout.
REQ-028 SHALL cover lock: DATA_PATH_WIDTH = 2, sel = 0, continuous valid PN9 words -> word 0 seeds, words 1..16 match, pn_oos falls 2 cycles after word 16 and pn_err stays 0.
REQ-029 SHALL cover a single error: while locked, one bit of one word flipped -> exactly one pn_err pulse 2 cycles later and pn_oos stays 0.
REQ-030 SHALL cover loss of lock: while locked, 16 consecutive all-zero words -> 16 pn_err pulses and pn_oos = 1 two cycles after the 16th.
REQ-031 SHALL cover a sequence change: sel 0 -> 1 while locked on PN9, then PN23 data -> pn_oos = 1 on the next cycle, then relock after 1+16 words.
REQ-032 SHALL cover gaps and reserved codes: valid toggled 1/0 during lock -> lock time counts valid words only; sel = 4'd7 -> pn_oos = 1 and pn_err = 0 indefinitely.
